// File: rtl/fifo_out_read_operation.sv
// Read-side pointer/occupancy controller for an 8-entry register-file FIFO.
// Optional soft clear input clr when FIFO_SOFT_CLR_EN is defined.
module fifo_out_read_operation #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
`ifdef FIFO_SOFT_CLR_EN
  input  logic                    clr,
`endif
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [8*DATA_WIDTH-1:0] reg_data,
  output logic [2:0]              wr_addr,
  output logic [2:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_ack,
  output logic                    rd_err,
  output logic                    wr_err,
  output logic [3:0]              data_count,
  output logic                    empty,
  output logic                    full
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_NORMAL = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              wr_addr_q, wr_addr_d;
  logic [2:0]              rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_ack_q, rd_ack_d;
  logic                    rd_err_q, rd_err_d;
  logic                    wr_err_q, wr_err_d;
  logic [3:0]              count_q, count_d;
  logic                    empty_q, empty_d;
  logic                    full_q, full_d;

  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_WIDTH-1:0]   ent [8];

  // Unflatten the register file so the read mux indexes cleanly.
  for (genvar k = 0; k < 8; k++) begin : g_ent
    assign ent[k] = reg_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Accept decisions, pointer/count/state next values and pulses.
  always_comb begin
    wr_acc    = wr_en & ~full_q;
    rd_acc    = rd_en & ~empty_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    state_d   = state_q;
    rd_ack_d  = rd_acc;
    rd_err_d  = rd_en & empty_q;
    wr_err_d  = wr_en & full_q;

    if (wr_acc) begin
      wr_addr_d = wr_addr_q + 3'd1;
    end
    if (rd_acc) begin
      rd_addr_d = rd_addr_q + 3'd1;
      rd_data_d = ent[rd_addr_q];
    end

    unique case (1'b1)
      (wr_acc & ~rd_acc): count_d = count_q + 4'd1;
      (rd_acc & ~wr_acc): count_d = count_q - 4'd1;
      default:            count_d = count_q;
    endcase

    unique case (state_q)
      S_EMPTY: begin
        if (wr_acc) state_d = S_NORMAL;
      end
      S_NORMAL: begin
        if (wr_acc && !rd_acc && count_q == 4'd7)
          state_d = S_FULL;
        else if (rd_acc && !wr_acc && count_q == 4'd1)
          state_d = S_EMPTY;
      end
      S_FULL: begin
        if (rd_acc) state_d = S_NORMAL;
      end
      default: state_d = S_EMPTY;
    endcase

`ifdef FIFO_SOFT_CLR_EN
    // Soft clear wins over any request; read data is left alone.
    if (clr) begin
      wr_addr_d = 3'd0;
      rd_addr_d = 3'd0;
      rd_data_d = rd_data_q;
      count_d   = 4'd0;
      state_d   = S_EMPTY;
      rd_ack_d  = 1'b0;
      rd_err_d  = 1'b0;
      wr_err_d  = 1'b0;
    end
`endif

    empty_d = (state_d == S_EMPTY);
    full_d  = (state_d == S_FULL);
  end

  // State, pointers, data and status flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_EMPTY;
      wr_addr_q <= 3'd0;
      rd_addr_q <= 3'd0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      count_q   <= 4'd0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      wr_err_q  <= wr_err_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign wr_err     = wr_err_q;
  assign data_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;

endmodule

// File: tb/tb_fifo_out_read_operation.sv
// Directed bench for fifo_out_read_operation.
// Covers FIFO_SOFT_CLR_EN clear when that macro is defined.
module tb_fifo_out_read_operation;

  logic         clk;
  logic         reset_n;
  logic         wr_en;
  logic         rd_en;
  logic [255:0] reg_data;
  logic [2:0]   wr_addr;
  logic [2:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         rd_ack;
  logic         rd_err;
  logic         wr_err;
  logic [3:0]   data_count;
  logic         empty;
  logic         full;
`ifdef FIFO_SOFT_CLR_EN
  logic         clr;
`endif

  int n_cmp;
  int n_err;

  fifo_out_read_operation #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef FIFO_SOFT_CLR_EN
    .clr        (clr),
`endif
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .reg_data   (reg_data),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .wr_err     (wr_err),
    .data_count (data_count),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r);
    wr_en = w;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic chk_st(input string tag,
                        input logic [3:0] cnt,
                        input logic [2:0] wa,
                        input logic [2:0] ra,
                        input logic e, input logic f);
    chk({tag, ".count"}, 32'(data_count), 32'(cnt));
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(wa));
    chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(ra));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
  endtask

  task automatic chk_pl(input string tag,
                        input logic ack,
                        input logic re,
                        input logic we);
    chk({tag, ".rd_ack"}, 32'(rd_ack), 32'(ack));
    chk({tag, ".rd_err"}, 32'(rd_err), 32'(re));
    chk({tag, ".wr_err"}, 32'(wr_err), 32'(we));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
`ifdef FIFO_SOFT_CLR_EN
    clr     = 1'b0;
`endif
    for (int k = 0; k < 8; k++)
      reg_data[k*32 +: 32] = 32'h1000 + 32'(k);

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    chk_st("rst", 4'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk_pl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.rd_data", rd_data, 32'h0);

    // Fill to 8, then one rejected write.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0);
      chk("fill.count", 32'(data_count), 32'(i));
      chk("fill.full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
    end
    chk_st("full", 4'd8, 3'd0, 3'd0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk_st("ovf", 4'd8, 3'd0, 3'd0, 1'b0, 1'b1);
    chk_pl("ovf", 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk_pl("ovf_idle", 1'b0, 1'b0, 1'b0);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1);
      chk("drain.rd_data", rd_data, 32'h1000 + 32'(i));
      chk("drain.rd_ack", 32'(rd_ack), 32'd1);
      chk("drain.rd_addr", 32'(rd_addr), 32'((i + 1) % 8));
    end
    chk_st("drained", 4'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk_pl("udf", 1'b0, 1'b1, 1'b0);
    chk("udf.rd_data", rd_data, 32'h1007);
    chk_st("udf", 4'd0, 3'd0, 3'd0, 1'b1, 1'b0);

    // Wrap: write 5, read 5, write 6, read 6.
    repeat (5) cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b1);
    repeat (6) cyc(1'b1, 1'b0);
    chk_st("wrap", 4'd6, 3'd3, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1);
      chk("wrap.rd_data", rd_data, 32'h1000 + 32'((i + 5) % 8));
    end
    chk_st("wrap_end", 4'd0, 3'd3, 3'd3, 1'b1, 1'b0);

    // Simultaneous read/write when empty.
    cyc(1'b1, 1'b1);
    chk_st("rw0", 4'd1, 3'd4, 3'd3, 1'b0, 1'b0);
    chk_pl("rw0", 1'b0, 1'b1, 1'b0);

    // Fill, then simultaneous when full.
    repeat (7) cyc(1'b1, 1'b0);
    chk_st("full2", 4'd8, 3'd3, 3'd3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk_st("rw8", 4'd7, 3'd3, 3'd4, 1'b0, 1'b0);
    chk_pl("rw8", 1'b1, 1'b0, 1'b1);
    chk("rw8.rd_data", rd_data, 32'h1003);

    // Simultaneous at count 3.
    repeat (4) cyc(1'b0, 1'b1);
    chk_st("pre3", 4'd3, 3'd3, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    chk_st("rw3", 4'd3, 3'd4, 3'd1, 1'b0, 1'b0);
    chk_pl("rw3", 1'b1, 1'b0, 1'b0);
    chk("rw3.rd_data", rd_data, 32'h1000);

    // Async reset mid-burst at count 4, no clock edge.
    cyc(1'b1, 1'b0);
    chk_st("pre_rst", 4'd4, 3'd5, 3'd1, 1'b0, 1'b0);
    wr_en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_st("arst", 4'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk_pl("arst", 1'b0, 1'b0, 1'b0);
    chk("arst.rd_data", rd_data, 32'h0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

`ifdef FIFO_SOFT_CLR_EN
    // Soft clear beats simultaneous read/write at count 4.
    repeat (4) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    chk_st("pre_clr", 4'd4, 3'd5, 3'd1, 1'b0, 1'b0);
    clr = 1'b1;
    cyc(1'b1, 1'b1);
    clr = 1'b0;
    chk_st("clr", 4'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    chk_pl("clr", 1'b0, 1'b0, 1'b0);
    chk("clr.rd_data", rd_data, 32'h1000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_out_read_operation.md
Name: fifo_out_read_operation

Overview:
Read-side controller for the 8-entry FIFO register file.
- Owns the read pointer, the write pointer and the occupancy state.
- Supplies the write address used by the write-enable decode path.
- Selects the entry at the read pointer and registers it on accepted reads.
- Produces full/empty status so the write side can gate its write enable.

Parameters:
DATA_WIDTH, 32, width of one register-file entry and of rd_data

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request from producer (same signal fed to the write-enable AND gates)
rd_en  input  1  read request from consumer
reg_data  input  8*DATA_WIDTH  flattened register-file contents; entry k at bits [k*DATA_WIDTH +: DATA_WIDTH]
wr_addr  output  3  write pointer; drives the 3-to-8 write decoder
rd_addr  output  3  read pointer
rd_data  output  DATA_WIDTH  registered read data
rd_ack  output  1  one-cycle pulse, rd_data valid
rd_err  output  1  one-cycle pulse, read rejected (empty)
wr_err  output  1  one-cycle pulse, write rejected (full)
data_count  output  4  occupancy, 0..8
empty  output  1  data_count==0
full  output  1  data_count==8

Behaviour:
- Reset (reset_n low, async):
  - wr_addr=0, rd_addr=0, rd_data=0, data_count=0.
  - rd_ack=0, rd_err=0, wr_err=0.
  - State=S_EMPTY, so empty=1, full=0.
- FSM, 3 states, 2-bit state register, flags decoded from state only (registered, glitch-free):
  - S_EMPTY (count 0)
  - S_NORMAL (count 1..7)
  - S_FULL (count 8)
- Accept rules, evaluated on current registered state:
  - wr_acc = wr_en & ~full
  - rd_acc = rd_en & ~empty
- On each rising edge:
  - wr_acc: wr_addr <= wr_addr+1, mod 8 (7 wraps to 0).
  - rd_acc:
    - rd_data <= reg_data entry[rd_addr], sampled at this edge.
    - rd_addr <= rd_addr+1, mod 8.
    - rd_ack=1 in the following cycle only.
  - rd_en & empty: rd_err=1 next cycle only; rd_data holds; rd_addr unchanged.
  - wr_en & full: wr_err=1 next cycle only; wr_addr unchanged. The write side must have its own gating; this block does not block the register-file write strobe.
  - Count update:
    - wr_acc only: +1.
    - rd_acc only: −1.
    - Both or neither: unchanged.
- State transitions:
  - S_EMPTY → S_NORMAL on wr_acc.
  - S_NORMAL → S_FULL on wr_acc & ~rd_acc & count==7.
  - S_NORMAL → S_EMPTY on rd_acc & ~wr_acc & count==1.
  - S_FULL → S_NORMAL on rd_acc.
  - All other cases hold state.
- Simultaneous rd_en & wr_en:
  - Empty: write accepted; read rejected with rd_err (no bypass); count 0→1.
  - Full: read accepted; write rejected with wr_err; count 8→7.
  - Otherwise both accepted; count unchanged.
- Latency: data written at address A becomes readable at the edge after the write edge. rd_data and rd_ack appear 1 cycle after the rd_en edge.
- rd_data holds its last value until the next accepted read.
- Reset asserted mid-operation clears all state immediately. Register-file contents are not touched by this block.
- Invariant: data_count == (wr_addr − rd_addr) mod 8, except when full, where the pointers are equal and data_count=8.

Optional Feature:
FIFO_SOFT_CLR_EN
- Defined:
  - Adds input port clr (1 bit).
  - clr high at an edge resets pointers, count and state to reset values.
  - clr clears rd_ack, rd_err and wr_err.
  - rd_data holds its value.
  - clr has priority over rd_en/wr_en in the same cycle.
- Undefined: no clr port; behaviour exactly as above.

Test Plan:
- Reset then idle 3 cycles → empty=1, full=0, data_count=0, wr_addr=0, rd_addr=0, rd_data=0, all pulses 0.
- Write 8 times with reg_data entry k=0x1000+k; then 1 extra wr_en → full=1 after the 8th write, data_count=8, wr_addr=0, wr_err pulse on the 9th.
- From full, read 8 times → rd_data=0x1000..0x1007 in order, rd_ack each cycle after rd_en, empty=1 after the 8th; 9th rd_en → rd_err pulse, rd_data stays 0x1007.
- Wrap: write 5, read 5, write 6 → wr_addr=3, rd_addr=5, data_count=6; read 6 → data order entries 5,6,7,0,1,2.
- Simultaneous rd_en&wr_en at count 0 → count=1, rd_err=1, rd_ack=0. At count 8 → count=7, wr_err=1, rd_ack=1. At count 3 → count=3, both pointers +1.
- Assert reset_n low asynchronously mid-burst at count 4 → outputs clear without waiting for a clock edge. With FIFO_SOFT_CLR_EN, clr with rd_en&wr_en at count 4 → count=0, no ack/err pulses.
